spi_burst_controller: RTL
=========================

// Module: spi_burst_controller
// PURPOSE
//  Sequences multi-byte SPI bursts on top of the byte-level spi_master.
//  Owns chip select (CS_n) and its setup, hold and idle timing.
//  Streams TX bytes from an upstream producer into the master one at a time,
//  and returns each received MISO byte upstream.
//  Sits between the system command logic and spi_master, in the same r_clk domain.
// PARAMETERS
//  MAX_BYTES      16  maximum burst length in bytes; LW = $clog2(MAX_BYTES+1)
//  CS_SETUP_CLKS   4  r_clk cycles CS_n is low before the first byte is issued (>=1)
//  CS_HOLD_CLKS    4  r_clk cycles CS_n stays low after the last r_m_done (>=1)
//  CS_IDLE_CLKS    2  r_clk cycles CS_n stays high before the next burst may start (>=1)
// PORTS
//  r_clk           in   1   system clock
//  r_reset         in   1   synchronous reset, active-high
//  r_start         in   1   single-cycle pulse: begin a burst of r_len bytes
//  r_len           in   LW  burst length, sampled with r_start; 0 = request ignored
//  w_busy          out  1   high from the cycle after an accepted start until w_done
//  w_done          out  1   single-cycle pulse: burst complete, CS idle time elapsed
//  r_tx_byte       in   8   next byte to send
//  r_tx_valid      in   1   r_tx_byte is valid
//  w_tx_ready      out  1   combinational: (state==LOAD) & r_m_ready; byte taken when valid&ready
//  w_rx_byte       out  8   received byte
//  w_rx_valid      out  1   single-cycle pulse qualifying w_rx_byte
//  w_m_data        out  8   byte to spi_master (r_data)
//  w_m_data_ready  out  1   single-cycle pulse to spi_master (r_data_ready)
//  r_m_ready       in   1   spi_master w_data_ready
//  r_m_done        in   1   spi_master w_master_done
//  r_m_rx          in   8   spi_master w_data
//  w_cs_n          out  1   chip select to slave, active-low
// BEHAVIOUR
//  Reset: state=IDLE, w_cs_n=1, w_busy=0, w_done=0, w_rx_valid=0,
//   w_m_data_ready=0, w_m_data=0, w_rx_byte=0, all counters=0.
//  Reset mid-burst: all outputs return to reset values on the next edge, including w_cs_n=1.
//   No w_done is issued; the aborted byte's r_m_done is ignored.
//  FSM: IDLE -> SETUP -> LOAD -> WAIT_DONE -> (LOAD | HOLD) -> GAP -> IDLE
//  IDLE: on r_start & r_len!=0: latch remaining<=r_len, w_cs_n<=0, w_busy<=1, go to SETUP.
//   r_start with r_len==0 produces no response.
//  SETUP: held exactly CS_SETUP_CLKS cycles, then LOAD.
//  LOAD: waits for r_tx_valid & r_m_ready (w_tx_ready high).
//   On the accepting edge: w_m_data<=r_tx_byte, w_m_data_ready<=1 for one cycle, go to WAIT_DONE.
//   TX underflow (r_tx_valid low): stall in LOAD with CS_n held low. No timeout.
//  WAIT_DONE: on r_m_done: w_rx_byte<=r_m_rx, w_rx_valid<=1 for one cycle, remaining<=remaining-1.
//   If remaining==1, go to HOLD; else go to LOAD.
//   r_m_ready is not sampled in WAIT_DONE.
//  HOLD: exactly CS_HOLD_CLKS cycles, then w_cs_n<=1 and go to GAP.
//  GAP: exactly CS_IDLE_CLKS cycles with CS_n high.
//   On the exit edge: w_done<=1 for one cycle, w_busy<=0, go to IDLE.
//  r_start is ignored whenever state!=IDLE, including the w_done cycle.
//  Timing with no stalls: start edge T0; w_cs_n=0 from T1; first w_m_data_ready high in cycle T(CS_SETUP_CLKS+2).
//  At most one byte is outstanding at the master.
//  Exactly r_len w_m_data_ready pulses and r_len w_rx_valid pulses occur per burst.
//  Counters are sized to their maximum value; none wraps.
//  Bytes are delivered and returned in order.
// TESTING
//  1. r_len=1, tx=0xA5, master model loops MOSI->MISO -> one w_m_data_ready with 0xA5;
//     w_rx_byte=0xA5; w_cs_n low exactly SETUP+load+xfer+HOLD cycles; w_done one cycle after GAP.
//  2. r_len=4, tx 0x01..0x04, slave returns 0xF0..0xF3 -> 4 in-order w_rx_valid pulses
//     with 0xF0..0xF3; w_cs_n never rises mid-burst.
//  3. r_len=3, r_tx_valid dropped for 20 cycles before byte 2 -> stall in LOAD;
//     w_cs_n stays 0; no extra w_m_data_ready; burst completes normally.
//  4. r_len=0 pulse, then r_start pulse while busy -> no CS activity for r_len=0;
//     second start has no effect; only one w_done for the original burst.
//  5. r_reset asserted during byte 2 of r_len=4 -> next cycle w_cs_n=1, w_busy=0;
//     no w_done; a fresh r_len=1 burst then completes correctly.
//  6. r_len=MAX_BYTES(16), back-to-back bursts -> 16 rx pulses each;
//     w_cs_n high >= CS_IDLE_CLKS between bursts.

Source files
------------

// File: rtl/spi_burst_controller.sv
// Multi-byte SPI burst sequencer sitting on top of a byte-level spi_master.
// Owns chip select and its setup/hold/idle timing, streaming TX bytes in and RX bytes out.
module spi_burst_controller #(
  parameter int MAX_BYTES     = 16,
  parameter int CS_SETUP_CLKS = 4,
  parameter int CS_HOLD_CLKS  = 4,
  parameter int CS_IDLE_CLKS  = 2,
  parameter int LW            = $clog2(MAX_BYTES + 1)
) (
  input  logic          r_clk,
  input  logic          r_reset,
  input  logic          r_start,
  input  logic [LW-1:0] r_len,
  output logic          w_busy,
  output logic          w_done,
  input  logic [7:0]    r_tx_byte,
  input  logic          r_tx_valid,
  output logic          w_tx_ready,
  output logic [7:0]    w_rx_byte,
  output logic          w_rx_valid,
  output logic [7:0]    w_m_data,
  output logic          w_m_data_ready,
  input  logic          r_m_ready,
  input  logic          r_m_done,
  input  logic [7:0]    r_m_rx,
  output logic          w_cs_n
);

  // One shared timer serves SETUP, HOLD and GAP; it only needs to reach the longest of them.
  localparam int TMAX_AB = (CS_SETUP_CLKS > CS_HOLD_CLKS) ? CS_SETUP_CLKS : CS_HOLD_CLKS;
  localparam int TMAX    = (TMAX_AB > CS_IDLE_CLKS) ? TMAX_AB : CS_IDLE_CLKS;
  localparam int TW      = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_WAIT_DONE,
    ST_HOLD,
    ST_GAP
  } state_t;

  state_t        state_reg, state_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic [LW-1:0] remaining_reg, remaining_next;
  logic          cs_n_reg, cs_n_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic          rx_valid_reg, rx_valid_next;
  logic [7:0]    rx_byte_reg, rx_byte_next;
  logic [7:0]    m_data_reg, m_data_next;
  logic          m_data_ready_reg, m_data_ready_next;

  always_ff @(posedge r_clk) begin
    if (r_reset) begin
      state_reg        <= ST_IDLE;
      timer_reg        <= '0;
      remaining_reg    <= '0;
      cs_n_reg         <= 1'b1;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      rx_valid_reg     <= 1'b0;
      rx_byte_reg      <= 8'h00;
      m_data_reg       <= 8'h00;
      m_data_ready_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      timer_reg        <= timer_next;
      remaining_reg    <= remaining_next;
      cs_n_reg         <= cs_n_next;
      busy_reg         <= busy_next;
      done_reg         <= done_next;
      rx_valid_reg     <= rx_valid_next;
      rx_byte_reg      <= rx_byte_next;
      m_data_reg       <= m_data_next;
      m_data_ready_reg <= m_data_ready_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    timer_next        = timer_reg;
    remaining_next    = remaining_reg;
    cs_n_next         = cs_n_reg;
    busy_next         = busy_reg;
    done_next         = 1'b0;
    rx_valid_next     = 1'b0;
    rx_byte_next      = rx_byte_reg;
    m_data_next       = m_data_reg;
    m_data_ready_next = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        // A start landing in the w_done cycle is dropped, keeping the idle gap intact.
        if (r_start && (r_len != '0) && !done_reg) begin
          remaining_next = r_len;
          cs_n_next      = 1'b0;
          busy_next      = 1'b1;
          timer_next     = '0;
          state_next     = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (timer_reg == TW'(CS_SETUP_CLKS - 1)) begin
          timer_next = '0;
          state_next = ST_LOAD;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      ST_LOAD: begin
        if (r_tx_valid && r_m_ready) begin
          m_data_next       = r_tx_byte;
          m_data_ready_next = 1'b1;
          state_next        = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (r_m_done) begin
          rx_byte_next   = r_m_rx;
          rx_valid_next  = 1'b1;
          remaining_next = remaining_reg - LW'(1);
          if (remaining_reg == LW'(1)) begin
            timer_next = '0;
            state_next = ST_HOLD;
          end else begin
            state_next = ST_LOAD;
          end
        end
      end
      ST_HOLD: begin
        if (timer_reg == TW'(CS_HOLD_CLKS - 1)) begin
          cs_n_next  = 1'b1;
          timer_next = '0;
          state_next = ST_GAP;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      ST_GAP: begin
        if (timer_reg == TW'(CS_IDLE_CLKS - 1)) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          timer_next = '0;
          state_next = ST_IDLE;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign w_tx_ready     = (state_reg == ST_LOAD) && r_m_ready;
  assign w_busy         = busy_reg;
  assign w_done         = done_reg;
  assign w_rx_byte      = rx_byte_reg;
  assign w_rx_valid     = rx_valid_reg;
  assign w_m_data       = m_data_reg;
  assign w_m_data_ready = m_data_ready_reg;
  assign w_cs_n         = cs_n_reg;

endmodule
